// File: rtl/pc_gen_pkg.sv
// Shared encodings and helpers for the fetch-stage PC generator and its
// return-address stack.
package pc_gen_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   typedef enum logic [2:0] {
      SEL_TRAP  = 3'd0,
      SEL_REDIR = 3'd1,
      SEL_HOLD  = 3'd2,
      SEL_RET   = 3'd3,
      SEL_SEQ   = 3'd4
   } pc_sel_e;

   // Both INSTR_BYTES and RAS_DEPTH are powers of two, so this is an exact log2.
   function automatic int unsigned pc_log2(input int unsigned val);
      return $clog2(val);
   endfunction

   // ALIGN_BITS = pc_log2(INSTR_BYTES), RAS_PTR_W = pc_log2(RAS_DEPTH)
   function automatic int unsigned align_bits(input int unsigned instr_bytes);
      return pc_log2(instr_bytes);
   endfunction

   function automatic int unsigned ras_ptr_w(input int unsigned ras_depth);
      return pc_log2(ras_depth);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// the count saturates at RAS_DEPTH.
module pc_ras
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4,
   localparam int unsigned RAS_PTR_W = ras_ptr_w(RAS_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic                 replace_i,
   input  logic                 clear_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic [XLEN-1:0]      rdata_top_o,
   output logic [RAS_PTR_W:0]   count_o,
   output logic                 empty_o,
   output logic                 full_o
);

   logic [RAS_PTR_W-1:0] top_q, top_d;
   logic [RAS_PTR_W:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]      mem_q [RAS_DEPTH];
   logic [XLEN-1:0]      mem_d [RAS_DEPTH];

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == (RAS_PTR_W+1)'(RAS_DEPTH));
   assign count_o     = cnt_q;
   assign rdata_top_o = mem_q[top_q];

   // The pointer wraps naturally, so a push when full lands on the oldest slot.
   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      mem_d = mem_q;
      if (clear_i) begin
         top_d = '0;
         cnt_d = '0;
      end else if (push_i) begin
         top_d        = top_q + 1'b1;
         mem_d[top_d] = wdata_i;
         if (!full_o) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         top_d = top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end else if (replace_i && !empty_o) begin
         mem_d[top_q] = wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: start/stall gated, prioritised next-PC mux
// (trap, redirect, hold, return prediction, sequential) and a return-address stack.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0080,
   parameter int unsigned     INSTR_BYTES = 4,
   parameter int unsigned     RAS_DEPTH   = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_i,
   input  logic            call_i,
   input  logic            ret_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            ras_empty_o,
   output logic            ras_full_o
);

   localparam int unsigned     ALIGN_BITS = align_bits(INSTR_BYTES);
   localparam int unsigned     RAS_PTR_W  = ras_ptr_w(RAS_DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

   logic [1:0]           state_q, state_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic                 vld_q, vld_d;
   pc_sel_e              sel;
   logic [XLEN-1:0]      pc_seq;
   logic                 ras_push, ras_pop, ras_replace, ras_clear, ras_ok;
   logic [XLEN-1:0]      ras_top;
   logic [RAS_PTR_W:0]   ras_count;
   logic                 ras_empty, ras_full, ras_has_entry;

   assign pc_seq        = pc_q + XLEN'(INSTR_BYTES);
   assign ras_has_entry = (ras_count != '0);

   // Trap and redirect are honoured while paused so a late redirect is not lost.
   always_comb begin
      sel = SEL_HOLD;
      case (state_q)
         ST_RUN: begin
            if (trap_i)                      sel = SEL_TRAP;
            else if (redirect_i)             sel = SEL_REDIR;
            else if (stall_i)                sel = SEL_HOLD;
            else if (ret_i && ras_has_entry) sel = SEL_RET;
            else                             sel = SEL_SEQ;
         end
         ST_PAUSE: begin
            if (trap_i)          sel = SEL_TRAP;
            else if (redirect_i) sel = SEL_REDIR;
         end
         default: sel = SEL_HOLD;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      case (sel)
         SEL_TRAP:  pc_d = TRAP_VEC;
         SEL_REDIR: pc_d = redirect_pc_i & ALIGN_MASK;
         SEL_RET:   pc_d = ras_top;
         SEL_SEQ:   pc_d = pc_seq;
         default:   pc_d = pc_q;
      endcase
   end

   // Call+return on a non-empty stack swaps the top instead of pop-then-push.
   always_comb begin
      ras_ok      = (sel == SEL_RET) || (sel == SEL_SEQ);
      ras_clear   = (sel == SEL_TRAP);
      ras_push    = ras_ok && call_i && !(ret_i && ras_has_entry);
      ras_pop     = ras_ok && ret_i && !call_i && ras_has_entry;
      ras_replace = ras_ok && ret_i && call_i && ras_has_entry;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i)  state_d = ST_RUN;
         ST_RUN:   if (!start_i) state_d = ST_PAUSE;
         ST_PAUSE: if (start_i)  state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
      vld_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VEC;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         vld_q   <= vld_d;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .replace_i   (ras_replace),
      .clear_i     (ras_clear),
      .wdata_i     (pc_seq),
      .rdata_top_o (ras_top),
      .count_o     (ras_count),
      .empty_o     (ras_empty),
      .full_o      (ras_full)
   );

   assign pc_o        = pc_q;
   assign pc_valid_o  = vld_q;
   assign ras_empty_o = ras_empty;
   assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VEC = 0x100, TRAP_VEC = 0x80, 4-byte
// instructions and a 4-entry return-address stack.
module tb_pc_gen;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i, stall_i, redirect_i, trap_i, call_i, ret_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_o;
   logic        pc_valid_o, ras_empty_o, ras_full_o;

   int checks = 0;
   int errors = 0;

   pc_gen #(
      .XLEN        (32),
      .RESET_VEC   (32'h0000_0100),
      .TRAP_VEC    (32'h0000_0080),
      .INSTR_BYTES (4),
      .RAS_DEPTH   (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .trap_i        (trap_i),
      .call_i        (call_i),
      .ret_i         (ret_i),
      .pc_o          (pc_o),
      .pc_valid_o    (pc_valid_o),
      .ras_empty_o   (ras_empty_o),
      .ras_full_o    (ras_full_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic exp_vld);
      check({tag, "_pc"}, pc_o, exp_pc);
      check({tag, "_vld"}, {31'd0, pc_valid_o}, {31'd0, exp_vld});
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_i    = 1'b1;
      redirect_pc_i = target;
      step();
      redirect_i    = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
      trap_i = 1'b0; call_i = 1'b0; ret_i = 1'b0; redirect_pc_i = 32'h0;
      #2 rst_i = 1'b0;
      #1;
      check_pc("reset", 32'h100, 1'b0);
      check("reset_empty", {31'd0, ras_empty_o}, 32'd1);
      check("reset_full",  {31'd0, ras_full_o},  32'd0);
      step();
      step();
      rst_i = 1'b1;

      // Idle ignores trap and redirect
      trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h400;
      step();
      trap_i = 1'b0; redirect_i = 1'b0;
      check_pc("idle_hold", 32'h100, 1'b0);

      // 1: start, then sequential fetch
      start_i = 1'b1;
      step(); check_pc("start", 32'h100, 1'b1);
      step(); check_pc("seq1", 32'h104, 1'b1);
      step(); check_pc("seq2", 32'h108, 1'b1);

      // 2: stall with call does not move PC or push
      stall_i = 1'b1; call_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_pc("stall", 32'h108, 1'b1);
         check("stall_empty", {31'd0, ras_empty_o}, 32'd1);
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h2003;
      step();
      check_pc("redir_align", 32'h2000, 1'b1);
      redirect_i = 1'b0; stall_i = 1'b0; call_i = 1'b0;

      // 3: call / return pair, then return on empty stack
      redirect_to(32'h40);
      check_pc("at40", 32'h40, 1'b1);
      call_i = 1'b1; step(); call_i = 1'b0;
      check_pc("after_call", 32'h44, 1'b1);
      check("call_empty", {31'd0, ras_empty_o}, 32'd0);
      redirect_to(32'h80);
      ret_i = 1'b1; step(); ret_i = 1'b0;
      check_pc("ret44", 32'h44, 1'b1);
      check("ret_empty", {31'd0, ras_empty_o}, 32'd1);
      redirect_to(32'h90);
      ret_i = 1'b1; step(); ret_i = 1'b0;
      check_pc("ret_on_empty", 32'h94, 1'b1);
      check("ret_on_empty_e", {31'd0, ras_empty_o}, 32'd1);

      // 4: five calls overflow a four-deep stack
      for (int k = 1; k <= 5; k++) begin
         redirect_to(32'h10 * k);
         call_i = 1'b1; step(); call_i = 1'b0;
      end
      check("ovf_full", {31'd0, ras_full_o}, 32'd1);
      ret_i = 1'b1;
      step(); check_pc("pop54", 32'h54, 1'b1);
      check("pop_notfull", {31'd0, ras_full_o}, 32'd0);
      step(); check_pc("pop44", 32'h44, 1'b1);
      step(); check_pc("pop34", 32'h34, 1'b1);
      step(); check_pc("pop24", 32'h24, 1'b1);
      check("drained", {31'd0, ras_empty_o}, 32'd1);
      step(); check_pc("pop_seq", 32'h28, 1'b1);
      ret_i = 1'b0;

      // Call and return together swap the top entry
      redirect_to(32'h200);
      call_i = 1'b1; step(); call_i = 1'b0;
      redirect_to(32'h300);
      call_i = 1'b1; ret_i = 1'b1; step(); call_i = 1'b0;
      check_pc("swap", 32'h204, 1'b1);
      check("swap_empty", {31'd0, ras_empty_o}, 32'd0);
      step(); ret_i = 1'b0;
      check_pc("swap_ret", 32'h304, 1'b1);
      check("swap_drained", {31'd0, ras_empty_o}, 32'd1);

      // 5: trap beats everything and clears the stack
      call_i = 1'b1; step(); call_i = 1'b0;
      check_pc("pre_trap", 32'h308, 1'b1);
      trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h500; stall_i = 1'b1; ret_i = 1'b1;
      step();
      trap_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0; ret_i = 1'b0;
      check_pc("trap", 32'h80, 1'b1);
      check("trap_clear", {31'd0, ras_empty_o}, 32'd1);
      step(); check_pc("post_trap", 32'h84, 1'b1);
      start_i = 1'b0;
      step(); check_pc("pause_enter", 32'h88, 1'b0);
      step(); check_pc("pause_hold", 32'h88, 1'b0);
      redirect_to(32'h604);
      check_pc("pause_redir", 32'h604, 1'b0);
      start_i = 1'b1;
      step(); check_pc("resume", 32'h604, 1'b1);
      step(); check_pc("resume_seq", 32'h608, 1'b1);

      // 6: address wrap, then asynchronous reset mid-run
      redirect_to(32'hFFFF_FFFC);
      check_pc("at_top", 32'hFFFF_FFFC, 1'b1);
      step(); check_pc("wrap", 32'h0, 1'b1);
      call_i = 1'b1; step(); call_i = 1'b0;
      check("pre_rst_empty", {31'd0, ras_empty_o}, 32'd0);
      #2 rst_i = 1'b0;
      #1;
      check_pc("async_rst", 32'h100, 1'b0);
      check("async_rst_empty", {31'd0, ras_empty_o}, 32'd1);
      check("async_rst_full",  {31'd0, ras_full_o},  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
